// File: rtl/cga_mem_pkg.sv
// Shared encodings for the CGA datapath's SRAM access path: arbiter states,
// engine direction codes and the default word/address widths.
package cga_mem_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        ISSUE   = ST_ISSUE,
        RELEASE = ST_RELEASE
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping modulo NUM_REQ; returns one-hot winner, its index and a valid flag.
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               valid
);

    int j;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        j          = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!valid && req[j]) begin
                winner[j]  = 1'b1;
                winner_idx = IDX_W'(j);
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin owner of the single SRAM word engine: one engine transaction per
// grant, one-cycle ack to the winner, per-transaction timeout with sticky flag.
//
// state   | meaning
// IDLE    | no owner; arbitrate and latch the winner's fields
// ISSUE   | mem_start high, waiting for mem_done or timeout
// RELEASE | mem_start low, waiting for the engine to drop mem_done
module sram_port_arbiter
    import cga_mem_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      mem_start,
    output logic                      mem_rw,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_done,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      timeout_err,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REQ - 1);

    arb_state_t         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [CNT_W-1:0]   tmo_cnt;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               any_req;
    logic [IDX_W-1:0]   ptr_after_owner;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (req),
        .ptr        (ptr),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .valid      (any_req)
    );

    assign ptr_after_owner = (owner == IDX_LAST) ? '0 : owner + IDX_W'(1);

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            tmo_cnt     <= '0;
            grant       <= '0;
            ack         <= '0;
            rdata       <= '0;
            mem_start   <= 1'b0;
            mem_rw      <= RD;
            mem_address <= '0;
            mem_wdata   <= '0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant       <= pick_onehot;
                        owner       <= pick_idx;
                        mem_rw      <= req_rw[pick_idx];
                        mem_address <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        mem_wdata   <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                        mem_start   <= 1'b1;
                        tmo_cnt     <= '0;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end

                ISSUE: begin
                    // done wins over a timeout that expires in the same cycle
                    if (mem_done) begin
                        if (mem_rw == RD) begin
                            rdata <= mem_rdata;
                        end
                        ack       <= grant;
                        grant     <= '0;
                        mem_start <= 1'b0;
                        ptr       <= ptr_after_owner;
                        state     <= RELEASE;
                    end else if (tmo_cnt == CNT_LAST) begin
                        timeout_err <= 1'b1;
                        ack         <= grant;
                        grant       <= '0;
                        mem_start   <= 1'b0;
                        ptr         <= ptr_after_owner;
                        state       <= RELEASE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end

                RELEASE: begin
                    // engine must see start low and drop done before the next grant
                    if (!mem_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    grant     <= '0;
                    mem_start <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed plus randomized bench for sram_port_arbiter with a behavioural
// SRAM engine and a round-robin reference model.
module tb_sram_port_arbiter;

    localparam int N   = 3;
    localparam int AW  = 20;
    localparam int DW  = 32;
    localparam int TMO = 64;

    logic            CLOCK_50 = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    req_rw;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    grant;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rdata;
    logic            mem_start;
    logic            mem_rw;
    logic [AW-1:0]   mem_address;
    logic [DW-1:0]   mem_wdata;
    logic            mem_done = 1'b0;
    logic [DW-1:0]   mem_rdata;
    logic            timeout_err;
    logic            busy;

    logic [AW-1:0] rq_addr  [N];
    logic [DW-1:0] rq_wdata [N];

    always #5 CLOCK_50 = ~CLOCK_50;

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = rq_addr[i];
            req_wdata[i*DW +: DW] = rq_wdata[i];
        end
    end

    sram_port_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .req         (req),
        .req_rw      (req_rw),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .grant       (grant),
        .ack         (ack),
        .rdata       (rdata),
        .mem_start   (mem_start),
        .mem_rw      (mem_rw),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_done    (mem_done),
        .mem_rdata   (mem_rdata),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    // Engine model: done after eng_delay cycles of start, held while start is
    // high, cleared eng_stale cycles late after start drops.
    int            eng_delay = 5;
    bit            eng_never = 1'b0;
    int            eng_stale = 0;
    logic [DW-1:0] eng_rdata = '0;
    int            st_cnt = 0;
    int            hold = 0;

    assign mem_rdata = eng_rdata;

    always @(posedge CLOCK_50) begin
        if (mem_start) begin
            st_cnt = st_cnt + 1;
            hold   = 0;
            if (!eng_never && st_cnt >= eng_delay) mem_done <= 1'b1;
        end else begin
            st_cnt = 0;
            if (mem_done) begin
                if (hold >= eng_stale) mem_done <= 1'b0;
                else hold = hold + 1;
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    int            m_ptr   = 0;
    logic [DW-1:0] m_rdata = '0;
    bit            m_terr  = 1'b0;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic do_txn(input int delay, input bit never, input int stale,
                          input logic [DW-1:0] rd, input bit keep,
                          input bit drop_early, output int gwait);
        int w, n, cyc, exp_lat;
        logic          e_rw;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        w = pick(req, m_ptr);
        if (w < 0) w = 0;
        eng_delay = delay;
        eng_never = never;
        eng_stale = stale;
        eng_rdata = rd;
        e_rw   = req_rw[w];
        e_addr = rq_addr[w];
        e_wd   = rq_wdata[w];
        n = 0;
        while (grant === '0 && n < 20) begin
            step();
            n++;
        end
        gwait = n;
        check("grant", 64'(grant), 64'(1 << w));
        check("grant_start", 64'(mem_start), 64'(1));
        check("grant_busy", 64'(busy), 64'(1));
        check("grant_rw", 64'(mem_rw), 64'(e_rw));
        check("grant_addr", 64'(mem_address), 64'(e_addr));
        check("grant_wdata", 64'(mem_wdata), 64'(e_wd));
        // requester-side changes after grant must not reach the engine
        rq_addr[w]  = ~rq_addr[w];
        rq_wdata[w] = ~rq_wdata[w];
        req_rw[w]   = ~req_rw[w];
        if (drop_early) req[w] = 1'b0;
        cyc = 0;
        while (ack === '0 && cyc < 100) begin
            step();
            cyc++;
            if (ack === '0) begin
                check("issue_grant", 64'(grant), 64'(1 << w));
                check("issue_start", 64'(mem_start), 64'(1));
                check("issue_rw", 64'(mem_rw), 64'(e_rw));
                check("issue_addr", 64'(mem_address), 64'(e_addr));
                check("issue_wdata", 64'(mem_wdata), 64'(e_wd));
            end
        end
        exp_lat = never ? TMO : delay + 1;
        if (!never && e_rw == 1'b0) m_rdata = rd;
        if (never) m_terr = 1'b1;
        check("ack_latency", 64'(cyc), 64'(exp_lat));
        check("ack", 64'(ack), 64'(1 << w));
        check("ack_start", 64'(mem_start), 64'(0));
        check("ack_grant", 64'(grant), 64'(0));
        check("ack_rdata", 64'(rdata), 64'(m_rdata));
        check("ack_timeout_err", 64'(timeout_err), 64'(m_terr));
        m_ptr = (w + 1) % N;
        if (!keep) req[w] = 1'b0;
        step();
        check("ack_pulse", 64'(ack), 64'(0));
        check("release_start", 64'(mem_start), 64'(0));
        check("release_grant", 64'(grant), 64'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gw, n, r;
        reset  = 1'b0;
        req    = '0;
        req_rw = '0;
        for (int i = 0; i < N; i++) begin
            rq_addr[i]  = '0;
            rq_wdata[i] = '0;
        end
        step();
        step();
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_ack", 64'(ack), 64'(0));
        check("rst_start", 64'(mem_start), 64'(0));
        check("rst_terr", 64'(timeout_err), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        check("rst_rw", 64'(mem_rw), 64'(0));
        check("rst_addr", 64'(mem_address), 64'(0));
        check("rst_wdata", 64'(mem_wdata), 64'(0));
        reset = 1'b1;
        step();
        check("idle_busy", 64'(busy), 64'(0));

        // single read from requester 1
        req[1] = 1'b1; req_rw[1] = 1'b0; rq_addr[1] = 20'h00010;
        do_txn(7, 1'b0, 0, 32'hDEADBEEF, 1'b0, 1'b0, gw);

        // single write from requester 0; rdata must stay DEADBEEF
        step(); step();
        req[0] = 1'b1; req_rw[0] = 1'b1; rq_addr[0] = 20'h00003; rq_wdata[0] = 32'h12345678;
        do_txn(5, 1'b0, 0, 32'hCAFEF00D, 1'b0, 1'b0, gw);

        // timeout, then a normal request still completes
        step(); step();
        req[2] = 1'b1; req_rw[2] = 1'b0; rq_addr[2] = 20'h0ABCD;
        do_txn(1, 1'b1, 0, 32'h0BADBAD0, 1'b0, 1'b0, gw);
        step();
        check("tmo_idle_busy", 64'(busy), 64'(0));
        req[1] = 1'b1; req_rw[1] = 1'b0; rq_addr[1] = 20'h00055;
        do_txn(3, 1'b0, 0, 32'h55AA55AA, 1'b0, 1'b0, gw);
        check("tmo_sticky", 64'(timeout_err), 64'(1));

        // reset in the middle of ISSUE
        step(); step();
        eng_delay = 40; eng_never = 1'b0; eng_stale = 0;
        req[0] = 1'b1;
        n = 0;
        while (grant === '0 && n < 20) begin step(); n++; end
        step(); step(); step();
        check("midissue_start_before", 64'(mem_start), 64'(1));
        reset = 1'b0;
        req   = '0;
        step();
        check("midrst_start", 64'(mem_start), 64'(0));
        check("midrst_grant", 64'(grant), 64'(0));
        check("midrst_ack", 64'(ack), 64'(0));
        check("midrst_terr", 64'(timeout_err), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_rdata", 64'(rdata), 64'(0));
        m_ptr = 0; m_rdata = '0; m_terr = 1'b0;
        step();
        check("midrst_ack_none", 64'(ack), 64'(0));

        // contention with all requests held: 001,010,100,001
        req = 3'b111;
        for (int i = 0; i < N; i++) begin
            req_rw[i]   = 1'(i & 1);
            rq_addr[i]  = 20'(32'h100 + i);
            rq_wdata[i] = 32'hA0000000 + i;
        end
        reset = 1'b1;
        for (int t = 0; t < 4; t++) begin
            do_txn(2 + t, 1'b0, 0, 32'h11110000 + t, 1'b1, 1'b0, gw);
        end
        req = '0;
        step(); step(); step();

        // stale done: no grant until the engine drops done
        req[2] = 1'b1; req_rw[2] = 1'b0; rq_addr[2] = 20'h00777;
        do_txn(4, 1'b0, 3, 32'h77777777, 1'b0, 1'b0, gw);
        req[0] = 1'b1; req_rw[0] = 1'b0; rq_addr[0] = 20'h00888;
        n = 0;
        while (mem_done === 1'b1 && n < 10) begin
            check("stale_grant", 64'(grant), 64'(0));
            check("stale_busy", 64'(busy), 64'(1));
            step();
            n++;
        end
        do_txn(2, 1'b0, 0, 32'h88888888, 1'b0, 1'b0, gw);
        check("stale_gap", 64'(gw), 64'(2));

        // randomized traffic against the round-robin model
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    req[i]      = 1'b1;
                    req_rw[i]   = 1'($urandom_range(0, 1));
                    rq_addr[i]  = 20'($urandom);
                    rq_wdata[i] = $urandom;
                end
            end
            if (req === '0) begin
                r = $urandom_range(0, N - 1);
                req[r]      = 1'b1;
                req_rw[r]   = 1'($urandom_range(0, 1));
                rq_addr[r]  = 20'($urandom);
                rq_wdata[r] = $urandom;
            end
            do_txn($urandom_range(1, 12), 1'b0, $urandom_range(0, 2), $urandom,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), gw);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
